simplez_io: RTL and testbench
=============================

Name: simplez_io

Overview:
- Memory-mapped I/O peripheral on the Simplez data/address bus, downstream of the CPU's store/load path.
- Occupies the top four words of the 512-word address space and provides:
  - a 4-bit LED output register;
  - an 8N1 serial transmitter with a status word.
- The CPU's memory-access logic uses `sel` to steer `busD` between main memory and this block.

Parameters:
- DATAW, 12, data bus width.
- ADDRW, 9, address bus width.
- BAUD_DIV, 104, clock cycles per serial bit (12 MHz / 115200). Legal range ≥ 2.

Ports:
- clk  in  1  system clock; all sequential logic updates on negedge clk, matching the CPU datapath.
- rstn  in  1  reset, synchronous, active-low.
- addr  in  ADDRW  bus address (RA).
- rd  in  1  read strobe (lec).
- wr  in  1  write strobe (esc).
- data_in  in  DATAW  write data from busD.
- data_out  out  DATAW  registered read data.
- sel  out  1  combinational; 1 when addr[8:2] == 7'b1111111 (addresses 508..511).
- leds  out  4  LED register.
- tx  out  1  serial line, idle high.

Behaviour:
- Register map:
  - 508 LEDS: R/W, bits[3:0]; upper bits read 0.
  - 509 STATUS: RO. bit0 = ready (1 when transmitter idle); bit1 = overrun; others 0. A read clears overrun on the same edge that returns it.
  - 510 TXDATA: WO; data_in[7:0] is the byte to send. Reads return 0.
  - 511 reserved: reads 0, writes ignored.
- Read latency:
  - data_out is loaded on the negedge where rd=1 and sel=1, and holds until the next such read.
  - rd with sel=0 loads 0.
- Writes take effect on the negedge where wr=1 and sel=1.
- rd and wr to the same address on the same edge: write commits and read returns the pre-write value.
- Reset (rstn=0 at negedge): leds=0, data_out=0, tx=1, state=IDLE, overrun=0, bit/baud counters=0. Applies mid-frame; the frame is aborted and tx returns high on that edge.
- TX state machine:
  - IDLE: tx=1, ready=1. A TXDATA write latches the byte into a shift register, sets baud counter=0, moves to START.
  - START: tx=0 for BAUD_DIV cycles, then DATA with bit index 0.
  - DATA: tx = shift[0]. Every BAUD_DIV cycles, shift right and increment index; after index 7 completes, go to STOP.
  - STOP: tx=1 for BAUD_DIV cycles, then IDLE.
- tx is driven from a register. The first START cycle is the edge following the accepting write, so the frame is exactly 10*BAUD_DIV cycles of line time. ready goes 0 on the accepting edge and returns 1 on the edge STOP completes.
- TXDATA write while not IDLE: byte dropped, the current frame is unaffected, overrun set to 1.
- Overrun set and STATUS read on the same edge: returned value shows overrun=1 and the flag stays 1 (set wins).
- Baud counter counts 0..BAUD_DIV-1 and wraps; bit index is 3 bits and saturates at 7 before STOP.

Test Plan (BAUD_DIV=4):
- Reset then idle: hold rstn=0 two cycles, release → leds=0, tx=1, read 509 returns 0x001 one edge after rd.
- LED write/read: write 0xFA5 to 508 → leds=4'h5; read 508 → data_out=0x005.
- Transmit 0x55: write 0x155 to 510 → tx low 4 cycles, then bits 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles. STATUS bit0=0 throughout and 1 at cycle 40.
- Overrun: write 0x0A3 to 510, 5 cycles later write 0x0FF to 510 → line carries 0xA3 only. Read 509 → 0x002. Second read 509 → 0x000 while busy.
- Reset mid-frame: start 0x00 send, assert rstn=0 at cycle 12 → tx=1 next edge, STATUS reads 0x001 after release, no residual bits.
- Decode/simultaneous: read addr 507 → sel=0, data_out=0. Same-edge rd+wr to 508 with leds=3, data 0x00C → data_out=0x003, leds=0xC.

Source files
------------

// File: rtl/simplez_io.sv
// simplez_io: memory-mapped I/O block occupying addresses 508..511 of the
// Simplez bus. Provides a 4-bit LED register and an 8N1 serial transmitter
// with a status word (ready, sticky overrun). All state changes on negedge clk.
module simplez_io #(
    parameter int DATAW    = 12,
    parameter int ADDRW    = 9,
    parameter int BAUD_DIV = 104
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [ADDRW-1:0] addr,
    input  logic             rd,
    input  logic             wr,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic             sel,
    output logic [3:0]       leds,
    output logic             tx
);

    localparam int         CNTW      = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNTW-1:0] BAUD_LAST = CNTW'(BAUD_DIV - 1);

    localparam logic [1:0] OFS_LEDS   = 2'd0;
    localparam logic [1:0] OFS_STATUS = 2'd1;
    localparam logic [1:0] OFS_TXDATA = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    tx_state_t        r_state;
    logic [CNTW-1:0]  r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic [3:0]       r_leds;
    logic [DATAW-1:0] r_data_out;
    logic             r_overrun;

    logic             w_ready;
    logic             w_wr_leds;
    logic             w_wr_tx;
    logic             w_tx_accept;
    logic             w_overrun_set;
    logic             w_rd_status;
    logic             w_baud_last;
    logic [DATAW-1:0] w_rd_data;
    logic             w_unused;

    // Top four words of the address space belong to this block.
    assign sel = &addr[ADDRW-1:2];

    assign w_ready       = (r_state == S_IDLE);
    assign w_wr_leds     = wr & sel & (addr[1:0] == OFS_LEDS);
    assign w_wr_tx       = wr & sel & (addr[1:0] == OFS_TXDATA);
    assign w_tx_accept   = w_wr_tx & w_ready;
    assign w_overrun_set = w_wr_tx & ~w_ready;
    assign w_rd_status   = rd & sel & (addr[1:0] == OFS_STATUS);
    assign w_baud_last   = (r_baud_cnt == BAUD_LAST);

    // Upper write-data bits have no destination in this block.
    assign w_unused = &{1'b0, data_in[DATAW-1:8]};

    // Read mux: value presented to data_out on a read edge.
    always_comb begin
        // NOTE: default first so every path assigns w_rd_data and no latch is inferred.
        w_rd_data = '0;
        if (sel) begin
            case (addr[1:0])
                OFS_LEDS:   w_rd_data[3:0] = r_leds;
                OFS_STATUS: w_rd_data[1:0] = {r_overrun | w_overrun_set, w_ready};
                default:    ;
            endcase
        end
    end

    // Bus-side registers: LED latch, read-data latch and sticky overrun flag.
    always_ff @(negedge clk) begin
        if (!rstn) begin
            r_leds     <= 4'h0;
            r_data_out <= '0;
            r_overrun  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates make a same-edge read return the pre-write value.
            if (w_wr_leds) begin
                r_leds <= data_in[3:0];
            end
            if (rd) begin
                r_data_out <= w_rd_data;
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (w_rd_status) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Transmit FSM: tx is registered and reflects the state being entered.
    always_ff @(negedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_tx_accept) begin
                        r_shift    <= data_in[7:0];
                        r_baud_cnt <= '0;
                        r_bit_idx  <= 3'd0;
                        r_state    <= S_START;
                        r_tx       <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= 3'd0;
                        r_state    <= S_DATA;
                        r_tx       <= r_shift[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign data_out = r_data_out;
    assign leds     = r_leds;
    assign tx       = r_tx;

endmodule

// File: tb/tb_simplez_io.sv
// Self-checking bench for simplez_io with BAUD_DIV=4. A frame-level model
// (10-bit frame vector plus elapsed line time) predicts every output.
module tb_simplez_io;

    localparam int BD = 4;

    logic        clk;
    logic        rstn;
    logic [8:0]  addr;
    logic        rd;
    logic        wr;
    logic [11:0] data_in;
    logic [11:0] data_out;
    logic        sel;
    logic [3:0]  leds;
    logic        tx;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [3:0]  m_leds;
    logic [11:0] m_dout;
    logic        m_ovr;
    logic        m_active;
    int          m_pos;
    logic [9:0]  m_frame;

    simplez_io #(
        .DATAW(12),
        .ADDRW(9),
        .BAUD_DIV(BD)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .addr(addr),
        .rd(rd),
        .wr(wr),
        .data_in(data_in),
        .data_out(data_out),
        .sel(sel),
        .leds(leds),
        .tx(tx)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    function automatic void model_edge(input logic r, input logic [8:0] a, input logic rd_i,
                                       input logic wr_i, input logic [7:0] d);
        logic        s;
        logic        rdy;
        logic        ovr_set;
        logic [11:0] rv;
        if (!r) begin
            m_leds = 4'h0; m_dout = 12'h000; m_ovr = 1'b0; m_active = 1'b0; m_pos = 0;
            return;
        end
        s       = (a >= 9'd508);
        rdy     = !m_active;
        ovr_set = wr_i && s && (a == 9'd510) && !rdy;
        rv      = 12'h000;
        if (s && a == 9'd508) rv = {8'h00, m_leds};
        if (s && a == 9'd509) rv = {10'b0, m_ovr | ovr_set, rdy};
        if (rd_i) m_dout = rv;
        if (m_active) begin
            m_pos++;
            if (m_pos == 10 * BD) m_active = 1'b0;
        end
        if (wr_i && s && a == 9'd508) m_leds = d[3:0];
        if (wr_i && s && a == 9'd510 && rdy) begin
            m_frame  = {1'b1, d, 1'b0};
            m_active = 1'b1;
            m_pos    = 0;
        end
        if (ovr_set) m_ovr = 1'b1;
        else if (rd_i && s && a == 9'd509) m_ovr = 1'b0;
    endfunction

    function automatic logic model_tx();
        return m_active ? m_frame[m_pos / BD] : 1'b1;
    endfunction

    // Apply inputs for one cycle; outputs are then sampled at the posedge.
    task automatic tick(input logic r, input logic [8:0] a, input logic rd_i,
                        input logic wr_i, input logic [11:0] d);
        rstn = r; addr = a; rd = rd_i; wr = wr_i; data_in = d;
        @(negedge clk);
        model_edge(r, a, rd_i, wr_i, d[7:0]);
        @(posedge clk);
    endtask

    task automatic test_reset();
        tick(1'b0, 9'd0, 1'b0, 1'b0, 12'h000);
        tick(1'b0, 9'd0, 1'b0, 1'b0, 12'h000);
        total++; if (leds !== m_leds) begin bad++; $display("FAIL reset_leds got=%h exp=%h", leds, m_leds); end
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
        total++; if (data_out !== m_dout) begin bad++; $display("FAIL reset_dout got=%h exp=%h", data_out, m_dout); end
        tick(1'b1, 9'd509, 1'b1, 1'b0, 12'h000);
        total++; if (data_out !== m_dout) begin bad++; $display("FAIL reset_status got=%h exp=%h", data_out, m_dout); end
    endtask

    task automatic test_leds();
        logic [11:0] v;
        tick(1'b1, 9'd508, 1'b0, 1'b1, 12'hFA5);
        total++; if (leds !== m_leds) begin bad++; $display("FAIL led_write got=%h exp=%h", leds, m_leds); end
        tick(1'b1, 9'd508, 1'b1, 1'b0, 12'h000);
        total++; if (data_out !== m_dout) begin bad++; $display("FAIL led_read got=%h exp=%h", data_out, m_dout); end
        for (int i = 0; i < 6; i++) begin
            v = 12'($urandom);
            tick(1'b1, 9'd508, 1'b0, 1'b1, v);
            total++; if (leds !== m_leds) begin bad++; $display("FAIL led_rand_w got=%h exp=%h", leds, m_leds); end
            tick(1'b1, 9'd508, 1'b1, 1'b0, 12'h000);
            total++; if (data_out !== m_dout) begin bad++; $display("FAIL led_rand_r got=%h exp=%h", data_out, m_dout); end
        end
    endtask

    task automatic test_transmit(input logic [7:0] b);
        tick(1'b1, 9'd510, 1'b0, 1'b1, {4'h1, b});
        total++; if (tx !== model_tx()) begin bad++; $display("FAIL tx_start got=%b exp=%b", tx, model_tx()); end
        for (int c = 1; c < 10 * BD + 4; c++) begin
            tick(1'b1, 9'd509, 1'b1, 1'b0, 12'h000);
            total++; if (tx !== model_tx()) begin bad++; $display("FAIL tx_line byte=%h cyc=%0d got=%b exp=%b", b, c, tx, model_tx()); end
            total++; if (data_out !== m_dout) begin bad++; $display("FAIL tx_status byte=%h cyc=%0d got=%h exp=%h", b, c, data_out, m_dout); end
        end
    endtask

    task automatic test_overrun();
        tick(1'b1, 9'd510, 1'b0, 1'b1, 12'h0A3);
        for (int c = 0; c < 5; c++) begin
            tick(1'b1, 9'd0, 1'b0, 1'b0, 12'h000);
            total++; if (tx !== model_tx()) begin bad++; $display("FAIL ovr_line_a got=%b exp=%b", tx, model_tx()); end
        end
        tick(1'b1, 9'd510, 1'b0, 1'b1, 12'h0FF);
        tick(1'b1, 9'd509, 1'b1, 1'b0, 12'h000);
        total++; if (data_out !== m_dout) begin bad++; $display("FAIL ovr_status1 got=%h exp=%h", data_out, m_dout); end
        tick(1'b1, 9'd509, 1'b1, 1'b0, 12'h000);
        total++; if (data_out !== m_dout) begin bad++; $display("FAIL ovr_status2 got=%h exp=%h", data_out, m_dout); end
        for (int c = 0; c < 10 * BD; c++) begin
            tick(1'b1, 9'd0, 1'b0, 1'b0, 12'h000);
            total++; if (tx !== model_tx()) begin bad++; $display("FAIL ovr_line_b cyc=%0d got=%b exp=%b", c, tx, model_tx()); end
        end
    endtask

    task automatic test_reset_mid_frame();
        tick(1'b1, 9'd510, 1'b0, 1'b1, 12'h000);
        for (int c = 0; c < 11; c++) tick(1'b1, 9'd0, 1'b0, 1'b0, 12'h000);
        total++; if (tx !== model_tx()) begin bad++; $display("FAIL mid_before got=%b exp=%b", tx, model_tx()); end
        tick(1'b0, 9'd0, 1'b0, 1'b0, 12'h000);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL mid_reset_tx got=%b exp=1", tx); end
        tick(1'b1, 9'd509, 1'b1, 1'b0, 12'h000);
        total++; if (data_out !== m_dout) begin bad++; $display("FAIL mid_status got=%h exp=%h", data_out, m_dout); end
        for (int c = 0; c < 10 * BD; c++) begin
            tick(1'b1, 9'd0, 1'b0, 1'b0, 12'h000);
            total++; if (tx !== model_tx()) begin bad++; $display("FAIL mid_residual cyc=%0d got=%b exp=%b", c, tx, model_tx()); end
        end
    endtask

    task automatic test_decode();
        tick(1'b1, 9'd507, 1'b1, 1'b0, 12'h000);
        total++; if (sel !== 1'b0) begin bad++; $display("FAIL dec_sel507 got=%b exp=0", sel); end
        total++; if (data_out !== m_dout) begin bad++; $display("FAIL dec_dout507 got=%h exp=%h", data_out, m_dout); end
        tick(1'b1, 9'd508, 1'b0, 1'b1, 12'h003);
        tick(1'b1, 9'd508, 1'b1, 1'b1, 12'h00C);
        total++; if (data_out !== m_dout) begin bad++; $display("FAIL dec_same_edge_dout got=%h exp=%h", data_out, m_dout); end
        total++; if (leds !== m_leds) begin bad++; $display("FAIL dec_same_edge_leds got=%h exp=%h", leds, m_leds); end
        tick(1'b1, 9'd511, 1'b1, 1'b1, 12'hFFF);
        total++; if (sel !== 1'b1) begin bad++; $display("FAIL dec_sel511 got=%b exp=1", sel); end
        total++; if (data_out !== m_dout) begin bad++; $display("FAIL dec_dout511 got=%h exp=%h", data_out, m_dout); end
        total++; if (leds !== m_leds) begin bad++; $display("FAIL dec_leds511 got=%h exp=%h", leds, m_leds); end
        tick(1'b1, 9'd510, 1'b1, 1'b0, 12'h000);
        total++; if (data_out !== m_dout) begin bad++; $display("FAIL dec_dout510 got=%h exp=%h", data_out, m_dout); end
    endtask

    task automatic test_random();
        logic [8:0]  a;
        logic        r, rdi, wri;
        logic [11:0] d;
        for (int c = 0; c < 800; c++) begin
            a   = 9'(504 + $urandom_range(0, 7));
            r   = ($urandom_range(0, 99) != 0);
            rdi = 1'($urandom_range(0, 1));
            wri = ($urandom_range(0, 5) == 0);
            d   = 12'($urandom);
            tick(r, a, rdi, wri, d);
            total++; if (sel !== (a >= 9'd508)) begin bad++; $display("FAIL rnd_sel cyc=%0d addr=%0d got=%b", c, a, sel); end
            total++; if (tx !== model_tx()) begin bad++; $display("FAIL rnd_tx cyc=%0d got=%b exp=%b", c, tx, model_tx()); end
            total++; if (leds !== m_leds) begin bad++; $display("FAIL rnd_leds cyc=%0d got=%h exp=%h", c, leds, m_leds); end
            total++; if (data_out !== m_dout) begin bad++; $display("FAIL rnd_dout cyc=%0d got=%h exp=%h", c, data_out, m_dout); end
        end
    endtask

    initial begin
        rstn = 1'b0; addr = 9'd0; rd = 1'b0; wr = 1'b0; data_in = 12'h000;
        m_leds = 4'h0; m_dout = 12'h000; m_ovr = 1'b0; m_active = 1'b0; m_pos = 0; m_frame = 10'h3FF;
        test_reset();
        test_leds();
        test_transmit(8'h55);
        test_transmit(8'($urandom));
        test_transmit(8'($urandom));
        test_overrun();
        test_reset_mid_frame();
        test_decode();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
